mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BEAT_W, default 64, meaning the memory beat width in bits.
REQ-002 SHALL have parameter BURST_LEN, default 4, meaning beats per cache line; LINE_W = BEAT_W*BURST_LEN (256 by default).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports i_addr input 32, i_read input 1, i_rdata output LINE_W and i_resp output 1, forming the I-cache fill port (read only).
REQ-006 SHALL have ports d_addr input 32, d_read input 1, d_write input 1, d_wdata input LINE_W, d_rdata output LINE_W and d_resp output 1, forming the D-cache fill/writeback port.
REQ-007 SHALL have ports bmem_addr output 32, bmem_read output 1, bmem_write output 1, bmem_wdata output BEAT_W and bmem_ready input 1, forming the burst-memory request side.
REQ-008 SHALL have ports bmem_rdata input BEAT_W and bmem_rvalid input 1, forming the burst-memory return side.

Function
REQ-009 SHALL implement FSM states IDLE, RD_ISSUE, RD_WAIT, WR_BURST and RESP; one transaction outstanding at a time.
REQ-010 IDLE SHALL sample requests; a pending request moves the FSM on the next edge to RD_ISSUE (read) or WR_BURST (write), latching grant, address and write line.
REQ-011 SHALL arbitrate round-robin: with both ports requesting in IDLE, grant goes to the port not granted last; after reset the first tie goes to dcache.
REQ-012 SHALL give d_write precedence if d_read and d_write are both high.
REQ-013 SHALL drive bmem_addr = {latched addr[31:5], 5'b0} during RD_ISSUE and WR_BURST; otherwise bmem_addr is don't-care.
REQ-014 RD_ISSUE SHALL assert bmem_read; it holds until bmem_ready=1, then the FSM moves to RD_WAIT on that edge.
REQ-015 RD_WAIT SHALL store bmem_rdata into line slice [BEAT_W*cnt +: BEAT_W] on each bmem_rvalid and increment cnt; the FSM goes to RESP on the beat with cnt==BURST_LEN-1.
REQ-016 WR_BURST SHALL assert bmem_write with bmem_wdata = latched line slice [BEAT_W*cnt +: BEAT_W]; cnt advances only when bmem_ready=1, and the FSM goes to RESP when the last beat is accepted.
REQ-017 RESP SHALL pulse exactly one of i_resp/d_resp (the granted port) for one cycle, then go to IDLE.
REQ-018 SHALL present the assembled line on i_rdata or d_rdata (granted port) in the RESP cycle and hold it until the next read completion to that port.
REQ-019 SHALL treat requesters as holding addr/data stable until resp and deasserting their request in the cycle after resp.
REQ-020 SHALL ignore bmem_rvalid in any state other than RD_WAIT.
REQ-021 SHALL never assert bmem_read and bmem_write in the same cycle.
REQ-022 SHALL have cnt width $clog2(BURST_LEN) and reset cnt to 0 on every entry to RD_ISSUE or WR_BURST.
REQ-023 Minimum read latency (ready=1, rvalid back-to-back from the cycle after issue) SHALL be request cycle t -> resp at t+2+BURST_LEN; minimum write latency SHALL be resp at t+1+BURST_LEN.

Reset
REQ-024 On rst, the FSM SHALL go to IDLE, cnt to 0 and the last grant to icache; i_resp, d_resp, bmem_read and bmem_write SHALL be 0 from the next cycle.
REQ-025 Reset asserted mid-burst SHALL abandon the transaction with no resp pulse; subsequent stray rvalid beats SHALL be ignored.
REQ-026 Line registers are SHALL NOT be reset; rdata outputs are undefined until the first read completion.

Verification
REQ-027 Icache read 0x0000_1234, ready=1, rvalid beats 0x11..,0x22..,0x33..,0x44.. -> bmem_addr 0x0000_1220, i_rdata {0x44..,0x33..,0x22..,0x11..}, i_resp one cycle at t+6.
REQ-028 Dcache write 0x8000_0040 line 0x0..03_0..02_0..01_0..00, ready low 2 cycles per beat -> bmem_wdata 0x0,1,2,3 in order, each held until ready, d_resp once.
REQ-029 Simultaneous i_read and d_read after reset -> dcache served first, icache next; repeated simultaneous requests alternate grants.
REQ-030 rst asserted during RD_WAIT after 2 beats -> no resp, FSM IDLE; 2 further rvalid beats ignored; next icache read completes correctly.
REQ-031 d_read and d_write both high -> write burst issued, bmem_read never high; check bmem_read&bmem_write==0 every cycle throughout.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the memory arbiter: I-cache fill port, D-cache fill/writeback
// port and the burst-memory request/return side.
interface mem_arbiter_if #(
  parameter int unsigned BEAT_W    = 64,
  parameter int unsigned BURST_LEN = 4
);
  localparam int unsigned LINE_W = BEAT_W * BURST_LEN;

  logic [31:0]       i_addr;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic [31:0]       d_addr;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;

  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  // Caches plus burst memory: everything that drives the arbiter
  modport master (
    output i_addr, i_read, d_addr, d_read, d_write, d_wdata,
    output bmem_ready, bmem_rdata, bmem_rvalid,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata
  );

  // The arbiter itself
  modport slave (
    input  i_addr, i_read, d_addr, d_read, d_write, d_wdata,
    input  bmem_ready, bmem_rdata, bmem_rvalid,
    output i_rdata, i_resp, d_rdata, d_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between I-cache and D-cache onto a single burst memory.
// One line transaction outstanding at a time; reads gather BURST_LEN beats,
// writes stream the latched line out beat by beat.
module mem_arbiter #(
  parameter int unsigned BEAT_W    = 64,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int unsigned LINE_W = BEAT_W * BURST_LEN;
  localparam int unsigned CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_BURST, RESP} state_t;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_t;

  state_t            state;
  gnt_t              grant;
  gnt_t              last_grant;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [LINE_W-1:0] wline;
  logic [LINE_W-1:0] rline;
  logic [LINE_W-1:0] rline_merged;
  logic [31:0]       req_addr;
  logic              d_req;
  logic              pick_d;
  logic              start;
  logic              start_wr;
  logic              last_beat;
  logic              wr_step;
  logic              rd_beat;
  logic              rd_done;

  // Arbitration decision and per-cycle datapath strobes
  always_comb begin
    d_req        = bus.d_read | bus.d_write;
    pick_d       = (d_req && bus.i_read) ? (last_grant == GNT_I) : d_req;
    start        = !rst && (state == IDLE) && (d_req || bus.i_read);
    start_wr     = start && pick_d && bus.d_write;
    req_addr     = pick_d ? bus.d_addr : bus.i_addr;
    last_beat    = (cnt == CNT_LAST);
    cnt_nxt      = cnt + CNT_W'(1);
    wr_step      = !rst && (state == WR_BURST) && bus.bmem_ready && !last_beat;
    rd_beat      = !rst && (state == RD_WAIT) && bus.bmem_rvalid;
    rd_done      = rd_beat && last_beat;
    rline_merged = rline;
    rline_merged[BEAT_W*cnt +: BEAT_W] = bus.bmem_rdata;
  end

  // Transaction FSM, beat counter, grant history and handshake strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      grant          <= GNT_I;
      last_grant     <= GNT_I;
      bus.i_resp     <= 1'b0;
      bus.d_resp     <= 1'b0;
      bus.bmem_read  <= 1'b0;
      bus.bmem_write <= 1'b0;
    end else begin
      bus.i_resp <= 1'b0;
      bus.d_resp <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            grant      <= pick_d ? GNT_D : GNT_I;
            last_grant <= pick_d ? GNT_D : GNT_I;
            cnt        <= '0;
            if (start_wr) begin
              bus.bmem_write <= 1'b1;
              state          <= WR_BURST;
            end else begin
              bus.bmem_read <= 1'b1;
              state         <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: begin
          if (bus.bmem_ready) begin
            bus.bmem_read <= 1'b0;
            state         <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rd_beat) begin
            if (last_beat) begin
              state      <= RESP;
              bus.i_resp <= (grant == GNT_I);
              bus.d_resp <= (grant == GNT_D);
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end
        WR_BURST: begin
          if (bus.bmem_ready) begin
            if (last_beat) begin
              bus.bmem_write <= 1'b0;
              state          <= RESP;
              bus.i_resp     <= (grant == GNT_I);
              bus.d_resp     <= (grant == GNT_D);
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Line-sized datapath; deliberately not reset, strobes already exclude rst
  always_ff @(posedge clk) begin
    if (start) bus.bmem_addr <= {req_addr[31:5], 5'b0};
    if (start_wr) begin
      wline          <= bus.d_wdata;
      bus.bmem_wdata <= bus.d_wdata[BEAT_W-1:0];
    end
    if (wr_step) bus.bmem_wdata <= wline[BEAT_W*cnt_nxt +: BEAT_W];
    if (rd_beat) rline <= rline_merged;
    if (rd_done && (grant == GNT_I)) bus.i_rdata <= rline_merged;
    if (rd_done && (grant == GNT_D)) bus.d_rdata <= rline_merged;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model with a per-cycle
// compare process, a burst-memory responder, and directed plus random traffic.
module tb_mem_arbiter;
  localparam int unsigned BEAT_W    = 64;
  localparam int unsigned BURST_LEN = 4;
  localparam int unsigned LINE_W    = BEAT_W * BURST_LEN;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.BEAT_W(BEAT_W), .BURST_LEN(BURST_LEN)) bus ();
  mem_arbiter #(.BEAT_W(BEAT_W), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  // phase: 0 free, 1 read request on bus, 2 collecting beats, 3 write burst, 4 response
  int                m_ph = 0;
  bit                m_port;     // 0 = icache, 1 = dcache
  bit                m_last;     // port granted most recently
  logic [31:0]       m_addr;
  logic [LINE_W-1:0] m_wline;
  logic [BEAT_W-1:0] m_beats[$];
  int                m_wacc;
  logic [LINE_W-1:0] exp_line[2];
  bit                line_known[2];
  logic [LINE_W-1:0] line_tmp;
  bit                chk_en = 1'b0;
  int                cyc = 0;
  int                resp_cnt[2];
  int                resp_log[$];
  int                rd_beats_seen = 0;
  bit                saw_read = 1'b0;
  logic [BEAT_W-1:0] wbeats[$];

  // Reference model update on each edge, then compare outputs just after it
  always @(posedge clk) begin
    bit d_req;
    cyc++;
    if (rst) begin
      m_ph   = 0;
      m_last = 1'b0;
      chk_en = 1'b1;
    end else if (chk_en) begin
      case (m_ph)
        0: begin
          d_req = bus.d_read || bus.d_write;
          if (d_req || bus.i_read) begin
            m_port = (d_req && bus.i_read) ? !m_last : d_req;
            m_last = m_port;
            m_addr = (m_port ? bus.d_addr : bus.i_addr) & 32'hFFFF_FFE0;
            m_beats.delete();
            m_wacc = 0;
            if (m_port && bus.d_write) begin
              m_wline = bus.d_wdata;
              m_ph    = 3;
            end else begin
              m_ph = 1;
            end
          end
        end
        1: if (bus.bmem_ready) m_ph = 2;
        2: begin
          if (bus.bmem_rvalid) begin
            m_beats.push_back(bus.bmem_rdata);
            rd_beats_seen++;
            if (m_beats.size() == BURST_LEN) begin
              for (int k = 0; k < BURST_LEN; k++) line_tmp[k*BEAT_W +: BEAT_W] = m_beats[k];
              exp_line[m_port]   = line_tmp;
              line_known[m_port] = 1'b1;
              m_ph = 4;
            end
          end
        end
        3: begin
          if (bus.bmem_ready) begin
            wbeats.push_back(bus.bmem_wdata);
            m_wacc++;
            if (m_wacc == BURST_LEN) m_ph = 4;
          end
        end
        default: m_ph = 0;
      endcase
    end
    #1;
    if (chk_en) begin
      check("rd_wr_exclusive", LINE_W'(bus.bmem_read & bus.bmem_write), '0);
      check("bmem_read", LINE_W'(bus.bmem_read), LINE_W'(m_ph == 1));
      check("bmem_write", LINE_W'(bus.bmem_write), LINE_W'(m_ph == 3));
      if (m_ph == 1 || m_ph == 3) check("bmem_addr", LINE_W'(bus.bmem_addr), LINE_W'(m_addr));
      if (m_ph == 3)
        check("bmem_wdata", LINE_W'(bus.bmem_wdata), LINE_W'(m_wline[m_wacc*BEAT_W +: BEAT_W]));
      check("i_resp", LINE_W'(bus.i_resp), LINE_W'(m_ph == 4 && !m_port));
      check("d_resp", LINE_W'(bus.d_resp), LINE_W'(m_ph == 4 && m_port));
      if (line_known[0]) check("i_rdata", bus.i_rdata, exp_line[0]);
      if (line_known[1]) check("d_rdata", bus.d_rdata, exp_line[1]);
      if (bus.i_resp === 1'b1) begin resp_cnt[0]++; resp_log.push_back(0); end
      if (bus.d_resp === 1'b1) begin resp_cnt[1]++; resp_log.push_back(1); end
      if (bus.bmem_read === 1'b1) saw_read = 1'b1;
    end
  end

  // ---------------- burst memory responder ----------------
  int                ready_mode = 0;  // 0 always ready, 1 random, 2 two-cycle stall per beat
  int                beats_left = 0;
  int                stall = 0;
  logic [BEAT_W-1:0] lit_beats[$];

  // Drive ready/rvalid half a cycle ahead of the sampling edge
  always @(negedge clk) begin
    case (ready_mode)
      0: bus.bmem_ready = 1'b1;
      1: bus.bmem_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (bus.bmem_read === 1'b1 || bus.bmem_write === 1'b1) begin
          if (stall < 2) begin bus.bmem_ready = 1'b0; stall++; end
          else begin bus.bmem_ready = 1'b1; stall = 0; end
        end else begin
          bus.bmem_ready = 1'b0;
          stall = 0;
        end
      end
    endcase
    if (beats_left > 0 && (ready_mode != 1 || $urandom_range(0, 3) != 0)) begin
      bus.bmem_rvalid = 1'b1;
      if (lit_beats.size() > 0) bus.bmem_rdata = lit_beats.pop_front();
      else bus.bmem_rdata = {$urandom, $urandom};
      beats_left--;
    end else begin
      bus.bmem_rvalid = (ready_mode == 1 && beats_left == 0 && $urandom_range(0, 7) == 0);
      bus.bmem_rdata  = {$urandom, $urandom};
    end
    if (bus.bmem_read === 1'b1 && bus.bmem_ready) beats_left = BURST_LEN;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic wait_resp(input bit port, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if ((port ? bus.d_resp : bus.i_resp) === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL resp_timeout: port %0d got no resp, required one within 400 cycles", port);
    end
  endtask

  task automatic i_txn(input logic [31:0] addr);
    bit ok;
    bus.i_addr = addr;
    bus.i_read = 1'b1;
    wait_resp(1'b0, ok);
    bus.i_read = 1'b0;
  endtask

  task automatic d_txn(input logic [31:0] addr, input bit rd, input bit wr,
                       input logic [LINE_W-1:0] line);
    bit ok;
    bus.d_addr  = addr;
    bus.d_wdata = line;
    bus.d_read  = rd;
    bus.d_write = wr;
    wait_resp(1'b1, ok);
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t0, t_resp, c0;
    logic [31:0]       seen_addr;
    logic [LINE_W-1:0] line;

    rst = 1'b1;
    bus.i_addr = '0; bus.i_read = 1'b0;
    bus.d_addr = '0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_wdata = '0;
    bus.bmem_ready = 1'b0; bus.bmem_rdata = '0; bus.bmem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_bmem_read",  LINE_W'(bus.bmem_read),  '0);
    check("reset_bmem_write", LINE_W'(bus.bmem_write), '0);
    check("reset_i_resp",     LINE_W'(bus.i_resp),     '0);
    check("reset_d_resp",     LINE_W'(bus.d_resp),     '0);
    rst = 1'b0;
    @(negedge clk);

    // Icache read at minimum latency with known beats
    ready_mode = 0;
    lit_beats.push_back(64'h1111_1111_1111_1111);
    lit_beats.push_back(64'h2222_2222_2222_2222);
    lit_beats.push_back(64'h3333_3333_3333_3333);
    lit_beats.push_back(64'h4444_4444_4444_4444);
    t0 = cyc; t_resp = -1; seen_addr = '0;
    bus.i_addr = 32'h0000_1234;
    bus.i_read = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.bmem_read === 1'b1) seen_addr = bus.bmem_addr;
      if (bus.i_resp === 1'b1) begin t_resp = cyc; break; end
    end
    bus.i_read = 1'b0;
    check("rd_bmem_addr", LINE_W'(seen_addr), LINE_W'(32'h0000_1220));
    check("rd_latency", LINE_W'(t_resp - t0), LINE_W'(6));
    check("rd_line", bus.i_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    @(negedge clk);

    // Dcache write with two stall cycles per beat
    ready_mode = 2;
    wbeats.delete();
    c0 = resp_cnt[1];
    d_txn(32'h8000_0040, 1'b0, 1'b1, {64'd3, 64'd2, 64'd1, 64'd0});
    repeat (3) @(negedge clk);
    check("wr_beat_count", LINE_W'(wbeats.size()), LINE_W'(4));
    for (int k = 0; k < 4; k++)
      if (k < wbeats.size()) check("wr_beat_value", LINE_W'(wbeats[k]), LINE_W'(k));
    check("wr_resp_once", LINE_W'(resp_cnt[1] - c0), LINE_W'(1));

    // Simultaneous requests right after reset alternate, dcache first
    ready_mode = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    resp_log.delete();
    fork
      begin
        bit ok;
        for (int n = 0; n < 2; n++) begin
          bus.d_addr = 32'h0000_4000 + 32'(n * 32);
          bus.d_read = 1'b1;
          wait_resp(1'b1, ok);
          bus.d_read = 1'b0;
          @(negedge clk);
        end
      end
      begin
        bit ok;
        for (int n = 0; n < 2; n++) begin
          bus.i_addr = 32'h0000_6000 + 32'(n * 32);
          bus.i_read = 1'b1;
          wait_resp(1'b0, ok);
          bus.i_read = 1'b0;
          @(negedge clk);
        end
      end
    join
    check("rr_count", LINE_W'(resp_log.size()), LINE_W'(4));
    for (int k = 0; k < 4; k++)
      if (k < resp_log.size()) check("rr_order", LINE_W'(resp_log[k]), LINE_W'((k % 2) == 0));

    // Reset after two beats of a read: abandoned, stray beats ignored
    repeat (2) @(negedge clk);
    lit_beats.delete();
    lit_beats.push_back(64'hAAAA_0000_0000_0001);
    lit_beats.push_back(64'hAAAA_0000_0000_0002);
    lit_beats.push_back(64'hAAAA_0000_0000_0003);
    lit_beats.push_back(64'hAAAA_0000_0000_0004);
    c0 = resp_cnt[0] + resp_cnt[1];
    rd_beats_seen = 0;
    bus.i_addr = 32'h0000_2000;
    bus.i_read = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rd_beats_seen >= 2) break;
    end
    check("abort_beats_seen", LINE_W'(rd_beats_seen), LINE_W'(2));
    rst = 1'b1;
    bus.i_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_resp", LINE_W'(resp_cnt[0] + resp_cnt[1] - c0), '0);
    check("abort_idle_read", LINE_W'(bus.bmem_read), '0);
    lit_beats.delete();
    lit_beats.push_back(64'h5555_0000_0000_0001);
    lit_beats.push_back(64'h5555_0000_0000_0002);
    lit_beats.push_back(64'h5555_0000_0000_0003);
    lit_beats.push_back(64'h5555_0000_0000_0004);
    i_txn(32'h0000_301C);
    check("post_abort_line", bus.i_rdata, {64'h5555_0000_0000_0004, 64'h5555_0000_0000_0003,
                                            64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001});
    @(negedge clk);

    // d_read and d_write together: write wins, no read strobe at all
    ready_mode = 1;
    line = rand_line();
    wbeats.delete();
    saw_read = 1'b0;
    d_txn(32'h4000_0080, 1'b1, 1'b1, line);
    @(negedge clk);
    check("rdwr_no_read", LINE_W'(saw_read), '0);
    check("rdwr_beat_count", LINE_W'(wbeats.size()), LINE_W'(4));
    for (int k = 0; k < 4; k++)
      if (k < wbeats.size()) check("rdwr_beat", LINE_W'(wbeats[k]), LINE_W'(line[k*BEAT_W +: BEAT_W]));

    // Random concurrent traffic from both ports against the model
    fork
      begin
        for (int n = 0; n < 25; n++) begin
          repeat ($urandom_range(1, 4)) @(negedge clk);
          i_txn($urandom);
        end
      end
      begin
        for (int n = 0; n < 25; n++) begin
          int kind;
          repeat ($urandom_range(1, 4)) @(negedge clk);
          kind = $urandom_range(0, 2);
          d_txn($urandom, kind != 1, kind != 0, rand_line());
        end
      end
    join

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop if the sequence ever stalls
  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
